// File: rtl/sevenseg_scanner_if.sv
// Display bus between data producers and the seven-segment scanner.
// Producers drive digit data and display controls; the scanner drives the board pins.
interface sevenseg_scanner_if #(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned DIM_BITS   = 3
);
   logic [NUM_DIGITS-1:0]   EN;
   logic [4*NUM_DIGITS-1:0] D;
   logic [NUM_DIGITS-1:0]   DP;
   logic [NUM_DIGITS-1:0]   BLINK;
   logic                    LZ_BLANK;
   logic [DIM_BITS-1:0]     BRIGHT;
   logic [NUM_DIGITS-1:0]   AN;
   logic [7:0]              C;
   logic                    FRAME;

   modport master (
      output EN, D, DP, BLINK, LZ_BLANK, BRIGHT,
      input  AN, C, FRAME
   );

   modport slave (
      input  EN, D, DP, BLINK, LZ_BLANK, BRIGHT,
      output AN, C, FRAME
   );
endinterface

// File: rtl/sevenseg_scanner.sv
// Multiplexed common-anode seven-segment scanner with per-digit decimal point and blink,
// PWM brightness, leading-zero blanking, one-cycle anti-ghosting dead time and a frame strobe.
module sevenseg_scanner #(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned TICK_BITS    = 17,
   parameter int unsigned DIM_BITS     = 3,
   parameter int unsigned BLINK_FRAMES = 64
) (
   input logic               CLK,
   input logic               RST,
   sevenseg_scanner_if.slave bus
);
   localparam int unsigned SLOT_BITS = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned FCNT_BITS = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [TICK_BITS-1:0] TICK_MAX  = '1;
   localparam logic [SLOT_BITS-1:0] SLOT_LAST = SLOT_BITS'(NUM_DIGITS - 1);
   localparam logic [FCNT_BITS-1:0] FCNT_LAST = FCNT_BITS'(BLINK_FRAMES - 1);

   logic [TICK_BITS-1:0]  tick_q, tick_d;
   logic [SLOT_BITS-1:0]  slot_q, slot_d;
   logic [FCNT_BITS-1:0]  frame_cnt_q, frame_cnt_d;
   logic                  hidden_q, hidden_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic [7:0]            c_q, c_d;
   logic                  frame_q, frame_d;

   logic                  frame_end;
   logic [NUM_DIGITS-1:0] suppress;
   logic                  zero_run;
   logic [3:0]            digit;
   logic                  lit;

   // Active-low segment pattern {g,f,e,d,c,b,a} for one hex digit.
   function automatic logic [6:0] decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   assign frame_end = (slot_q == SLOT_LAST) && (tick_q == TICK_MAX);

   // Scan counters: tick prescaler, slot select, frame count and blink phase.
   always_comb begin
      tick_d      = tick_q + 1'b1;
      slot_d      = slot_q;
      frame_cnt_d = frame_cnt_q;
      hidden_d    = hidden_q;
      if (tick_q == TICK_MAX) begin
         slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
      end
      if (frame_end) begin
         if (frame_cnt_q == FCNT_LAST) begin
            frame_cnt_d = '0;
            hidden_d    = ~hidden_q;
         end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
         end
      end
   end

   // Leading-zero suppression: a digit is blank if it and every digit above it is a bare zero.
   always_comb begin
      suppress = '0;
      zero_run = 1'b1;
      for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
         zero_run    = zero_run & (bus.D[4*i +: 4] == 4'h0) & ~bus.DP[i];
         suppress[i] = bus.LZ_BLANK & zero_run;
      end
   end

   // Next pin values for the current slot; tick 0 is dead time so anodes never overlap.
   always_comb begin
      digit   = bus.D[{slot_q, 2'b00} +: 4];
      lit     = bus.EN[slot_q] & ~(bus.BLINK[slot_q] & hidden_q) & ~suppress[slot_q] &
                (tick_q != '0) & (tick_q[TICK_BITS-1 -: DIM_BITS] <= bus.BRIGHT);
      an_d    = '1;
      c_d     = 8'hFF;
      frame_d = frame_end;
      if (lit) begin
         an_d[slot_q] = 1'b0;
         c_d          = {~bus.DP[slot_q], decode(digit)};
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         tick_q      <= '0;
         slot_q      <= '0;
         frame_cnt_q <= '0;
         hidden_q    <= 1'b0;
         an_q        <= '1;
         c_q         <= 8'hFF;
         frame_q     <= 1'b0;
      end else begin
         tick_q      <= tick_d;
         slot_q      <= slot_d;
         frame_cnt_q <= frame_cnt_d;
         hidden_q    <= hidden_d;
         an_q        <= an_d;
         c_q         <= c_d;
         frame_q     <= frame_d;
      end
   end

   assign bus.AN    = an_q;
   assign bus.C     = c_q;
   assign bus.FRAME = frame_q;
endmodule
